// File: rtl/cordic_pkg.sv
// Shared constants for the Q16.16 rotation-mode CORDIC: widths, stage count,
// the per-stage arctangent table and the pre-scale gain.
package cordic_pkg;

    localparam int WIDTH     = 32;
    localparam int FRAC_BITS = 16;
    localparam int N_STAGES  = 16;
    localparam int CORDIC_K  = 39797;

    // atan(2^-i) * 2^FRAC_BITS, indexed by stage
    localparam logic [WIDTH-1:0] ATAN_TABLE [N_STAGES] = '{
        32'd51471, 32'd30385, 32'd16054, 32'd8149,
        32'd4090,  32'd2047,  32'd1023,  32'd511,
        32'd255,   32'd127,   32'd63,    32'd31,
        32'd15,    32'd7,     32'd3,     32'd1
    };

    function automatic logic [WIDTH-1:0] stage_tan(input int stage);
        return ATAN_TABLE[stage];
    endfunction

endpackage

// File: rtl/cordic_pipeline.sv
// Sixteen chained micro-rotation stages forming the sine/cosine rotator;
// x must arrive pre-scaled by CORDIC_K.
module cordic_pipeline
    import cordic_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             out_valid
);

    logic [WIDTH-1:0] x_w [N_STAGES+1];
    logic [WIDTH-1:0] y_w [N_STAGES+1];
    logic [WIDTH-1:0] z_w [N_STAGES+1];
    logic [N_STAGES:0] v_w;

    assign x_w[0] = x;
    assign y_w[0] = y;
    assign z_w[0] = z;
    assign v_w[0] = in_valid;

    generate
        for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
            cordic_shift_accumulate #(
                .WIDTH (WIDTH),
                .STAGE (gi)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (v_w[gi]),
                .x         (x_w[gi]),
                .y         (y_w[gi]),
                .z         (z_w[gi]),
                .tan       (stage_tan(gi)),
                .x_out     (x_w[gi+1]),
                .y_out     (y_w[gi+1]),
                .z_out     (z_w[gi+1]),
                .out_valid (v_w[gi+1])
            );
        end
    endgenerate

    assign x_out     = x_w[N_STAGES];
    assign y_out     = y_w[N_STAGES];
    assign z_out     = z_w[N_STAGES];
    assign out_valid = v_w[N_STAGES];

endmodule

// File: rtl/cordic_shift_accumulate.sv
// One CORDIC micro-rotation: shift-and-add on x/y, angle-table accumulate on z,
// all registered with a single cycle of latency.
module cordic_shift_accumulate #(
    parameter int WIDTH = cordic_pkg::WIDTH,
    parameter int STAGE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] tan,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic             out_valid
);

    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] y_sh;
    logic             dir_neg;
    logic [WIDTH-1:0] x_next, y_next, z_next;
    logic [WIDTH-1:0] x_reg, y_reg, z_reg;
    logic             valid_reg;

    // arithmetic shift floors negative values toward -infinity
    assign x_sh    = $signed(x) >>> STAGE;
    assign y_sh    = $signed(y) >>> STAGE;
    assign dir_neg = z[WIDTH-1];

    always_comb begin
        x_next = x - y_sh;
        y_next = y + x_sh;
        z_next = z - tan;
        if (dir_neg) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + tan;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            valid_reg <= 1'b0;
        end else begin
            x_reg     <= x_next;
            y_reg     <= y_next;
            z_reg     <= z_next;
            valid_reg <= in_valid;
        end
    end

    assign x_out     = x_reg;
    assign y_out     = y_reg;
    assign z_out     = z_reg;
    assign out_valid = valid_reg;

endmodule

// File: tb/tb_cordic_shift_accumulate.sv
// Scoreboard bench for the CORDIC stage (STAGE 0, 1, 10) and the 16-stage chain.
module tb_cordic_shift_accumulate;
    import cordic_pkg::*;

    localparam logic [31:0] TAN0  = 32'd51471;
    localparam logic [31:0] TAN1  = 32'd30385;
    localparam logic [31:0] TAN10 = 32'd63;
    localparam int SEL_P = 99;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] xi = '0, yi = '0, zi = '0;
    logic        v0 = 1'b0, v1 = 1'b0, v10 = 1'b0, vp = 1'b0;

    logic [31:0] x0, y0, z0, x1, y1, z1, xa, ya, za, xp, yp, zp;
    logic        ov0, ov1, ova, ovp;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_shift_accumulate #(.WIDTH(32), .STAGE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .x(xi), .y(yi), .z(zi), .tan(TAN0),
        .x_out(x0), .y_out(y0), .z_out(z0), .out_valid(ov0));
    cordic_shift_accumulate #(.WIDTH(32), .STAGE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .x(xi), .y(yi), .z(zi), .tan(TAN1),
        .x_out(x1), .y_out(y1), .z_out(z1), .out_valid(ov1));
    cordic_shift_accumulate #(.WIDTH(32), .STAGE(10)) u10 (
        .clk(clk), .rst_n(rst_n), .in_valid(v10), .x(xi), .y(yi), .z(zi), .tan(TAN10),
        .x_out(xa), .y_out(ya), .z_out(za), .out_valid(ova));
    cordic_pipeline up (
        .clk(clk), .rst_n(rst_n), .in_valid(vp), .x(xi), .y(yi), .z(zi),
        .x_out(xp), .y_out(yp), .z_out(zp), .out_valid(ovp));

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        int          tol;
        int          due;
    } exp_t;

    exp_t q0[$], q1[$], q10[$], qp[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int tol);
        int d;
        d = $signed(act - exp);
        if (d < 0) d = -d;
        total++;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (tol %0d)", nm, act, exp, tol);
        end
    endtask

    task automatic check_out(input string nm, input logic [31:0] ax, input logic [31:0] ay,
                             input logic [31:0] az, input exp_t e);
        $display("txn %s cyc=%0d x=%08h y=%08h z=%08h (exp %08h %08h %08h)",
                 nm, cyc, ax, ay, az, e.x, e.y, e.z);
        chk({nm, ".x"}, ax, e.x, e.tol);
        chk({nm, ".y"}, ay, e.y, e.tol);
        chk({nm, ".z"}, az, e.z, e.tol);
        total++;
        if (cyc != e.due) begin
            bad++;
            $display("FAIL %s.latency: arrived cycle %0d expected cycle %0d", nm, cyc, e.due);
        end
    endtask

    task automatic extra(input string nm);
        total++;
        bad++;
        $display("FAIL %s.extra: out_valid=1 with nothing expected", nm);
    endtask

    // monitor: pops and compares whenever a DUT presents valid output
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ov0) begin
                if (q0.size() == 0) extra("u0");
                else begin e = q0.pop_front(); check_out("u0", x0, y0, z0, e); end
            end
            if (ov1) begin
                if (q1.size() == 0) extra("u1");
                else begin e = q1.pop_front(); check_out("u1", x1, y1, z1, e); end
            end
            if (ova) begin
                if (q10.size() == 0) extra("u10");
                else begin e = q10.pop_front(); check_out("u10", xa, ya, za, e); end
            end
            if (ovp) begin
                if (qp.size() == 0) extra("chain");
                else begin e = qp.pop_front(); check_out("chain", xp, yp, zp, e); end
            end
        end
    end

    task automatic send(input int sel, input logic [31:0] vx, input logic [31:0] vy,
                        input logic [31:0] vz, input logic [31:0] ex, input logic [31:0] ey,
                        input logic [31:0] ez, input int tol);
        exp_t e;
        e.x = ex; e.y = ey; e.z = ez; e.tol = tol;
        e.due = cyc + ((sel == SEL_P) ? N_STAGES : 1);
        xi = vx; yi = vy; zi = vz;
        v0 = (sel == 0); v1 = (sel == 1); v10 = (sel == 10); vp = (sel == SEL_P);
        case (sel)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            10:      q10.push_back(e);
            default: qp.push_back(e);
        endcase
        @(posedge clk); #1;
    endtask

    task automatic idle();
        v0 = 1'b0; v1 = 1'b0; v10 = 1'b0; vp = 1'b0;
        xi = 32'hDEAD_BEEF; yi = 32'h1234_5678; zi = 32'h8765_4321;
        @(posedge clk); #1;
    endtask

    initial begin
        // async reset before any clock edge
        #1 rst_n = 1'b0;
        #2;
        chk("rst0.x", x0, 32'h0, 0);
        chk("rst0.y", y0, 32'h0, 0);
        chk("rst0.z", z0, 32'h0, 0);
        chk("rst0.valid", {31'b0, ov0}, 32'h0, 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // test-plan vectors
        send(0,  32'h0001_0000, 32'h0, 32'h0,
                 32'h0001_0000, 32'h0001_0000, 32'hFFFF_36F1, 0);
        send(1,  32'h0001_0000, 32'h0001_0000, 32'hFFFF_36F1,
                 32'h0001_8000, 32'h0000_8000, 32'hFFFF_ADA2, 0);
        send(10, 32'hFFFF_0000, 32'h0000_0400, 32'h0,
                 32'hFFFE_FFFF, 32'h0000_03C0, 32'hFFFF_FFC1, 0);
        send(10, 32'h0, 32'hFFFF_FFFF, 32'h0,
                 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFC1, 0);
        idle();

        // back-to-back on stage 0, incl. most-negative z and wraparound
        send(0, 32'h0002_0000, 32'h0001_0000, 32'h0000_1000,
                32'h0001_0000, 32'h0003_0000, 32'hFFFF_46F1, 0);
        send(0, 32'h0003_0000, 32'hFFFF_0000, 32'h8000_0000,
                32'h0002_0000, 32'hFFFC_0000, 32'h8000_C90F, 0);
        send(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0,
                32'h8000_0000, 32'h7FFF_FFFE, 32'hFFFF_36F1, 0);
        // valid pattern 1,0,1
        send(0, 32'h5, 32'h3, 32'h7FFF_FFFF,
                32'h2, 32'h8, 32'h7FFF_36F0, 0);
        idle();
        send(0, 32'h0, 32'h0, 32'hFFFF_FFFF,
                32'h0, 32'h0, 32'h0000_C90E, 0);
        idle();
        idle();

        // asynchronous reset between edges with nonzero outputs
        send(0, 32'h0002_0000, 32'h0001_0000, 32'h0000_1000,
                32'h0001_0000, 32'h0003_0000, 32'hFFFF_46F1, 0);
        @(negedge clk); #1;
        v0 = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst.x", x0, 32'h0, 0);
        chk("arst.y", y0, 32'h0, 0);
        chk("arst.z", z0, 32'h0, 0);
        chk("arst.valid", {31'b0, ov0}, 32'h0, 0);
        @(posedge clk); #1;
        chk("hold.x", x0, 32'h0, 0);
        chk("hold.valid", {31'b0, ov0}, 32'h0, 0);
        @(negedge clk);
        v0 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel1.valid", {31'b0, ov0}, 32'h0, 0);
        @(posedge clk); #1;
        chk("rel2.valid", {31'b0, ov0}, 32'h0, 0);

        // first capture after release
        send(1, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_36F1,
                32'h0001_8000, 32'h0000_8000, 32'hFFFF_ADA2, 0);
        idle();

        // full 16-stage rotator: 30 degrees and 0 degrees
        send(SEL_P, 32'(CORDIC_K), 32'h0, 32'd34315,
                    32'd56756, 32'd32768, 32'd0, 16);
        send(SEL_P, 32'(CORDIC_K), 32'h0, 32'd0,
                    32'd65536, 32'd0, 32'd0, 16);
        for (int i = 0; i < 40; i++) begin
            if (q0.size() + q1.size() + q10.size() + qp.size() == 0) break;
            idle();
        end
        idle();

        total++;
        if (q0.size() + q1.size() + q10.size() + qp.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d outputs never appeared, expected 0",
                     q0.size() + q1.size() + q10.size() + qp.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_shift_accumulate.md
Name: cordic_shift_accumulate

Overview:
- One pipelined micro-rotation stage of a rotation-mode CORDIC engine working on signed Q16.16 fixed-point data.
- Sixteen instances with STAGE = 0..15 are chained to form the sine/cosine rotator.
- The stage index fixes the arithmetic shift amount.
- The per-stage arctangent constant, atan(2^-STAGE) scaled by 65536, arrives on an input port.

Parameters:
- WIDTH, 32, data width of x/y/z and tan (two's complement, Q16.16).
- STAGE, 0, iteration index i; shift amount applied to x and y (valid range 0..WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies x/y/z this cycle.
- x  input  WIDTH  signed x coordinate.
- y  input  WIDTH  signed y coordinate.
- z  input  WIDTH  signed residual angle.
- tan  input  WIDTH  atan(2^-STAGE)*65536, unsigned magnitude (e.g. 51471 for stage 0).
- x_out  output  WIDTH  registered rotated x.
- y_out  output  WIDTH  registered rotated y.
- z_out  output  WIDTH  registered updated residual angle.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Reset: rst_n low asynchronously clears x_out, y_out, z_out and out_valid to 0, independent of clk. Outputs stay 0 while rst_n is low.
- Release: first capture occurs on the first rising clk edge with rst_n high.
- Direction d: sign bit of z. d=0 (z >= 0) rotates counter-clockwise; d=1 (z < 0) rotates clockwise. z = 0 counts as non-negative.
- d=0: x_out <= x - (y >>> STAGE); y_out <= y + (x >>> STAGE); z_out <= z - tan.
- d=1: x_out <= x + (y >>> STAGE); y_out <= y - (x >>> STAGE); z_out <= z + tan.
- Shifts: arithmetic, so negative values round toward -infinity. STAGE=0 means no shift.
- Width: all sums are WIDTH bits and wrap modulo 2^WIDTH, with no saturation and no growth bits. tan is zero-extended, or used directly at WIDTH.
- Latency: exactly 1 clk; one new sample accepted every cycle. There is no stall/backpressure.
- out_valid <= in_valid each cycle. x/y/z registers update every cycle regardless of in_valid; data is meaningful only when out_valid is high.
- Reset mid-stream: any in-flight sample is discarded; out_valid stays low until in_valid is sampled high after release.
- Gain: no gain compensation in the stage. The caller pre-scales x by K = 0.607253 (0x9B75).

Decomposition:
- Shared package cordic_pkg holds:
  - WIDTH = 32 and FRAC_BITS = 16;
  - N_STAGES = 16;
  - the ATAN_TABLE constant array {51471, 30385, 16054, 8149, 4090, 2047, 1023, 511, 255, 127, 63, 31, 15, 7, 3, 1};
  - CORDIC_K = 39797.
- The stage is the single natural leaf sub-module. The chain wrapper (cordic_pipeline) instantiates it 16 times via generate, feeding tan from ATAN_TABLE[STAGE].

Test Plan:
- STAGE=0, tan=51471, x=0x00010000, y=0, z=0, in_valid=1 -> next edge: x_out=0x00010000, y_out=0x00010000, z_out=0xFFFF36F1, out_valid=1.
- STAGE=1, tan=30385, x=0x00010000, y=0x00010000, z=0xFFFF36F1 (negative) -> x_out=0x00018000, y_out=0x00008000, z_out=0xFFFFADA2.
- STAGE=10, tan=63, x=0xFFFF0000, y=0x00000400, z=0 -> x_out=0xFFFEFFFF, y_out=0x000003C0, z_out=0xFFFFFFC1 (checks arithmetic shift of a negative value).
- Reset: load nonzero outputs, then pull rst_n low between edges -> x_out/y_out/z_out/out_valid read 0 immediately without a clock edge. With in_valid=0 after release -> out_valid stays 0.
- Throughput: apply three different vectors on consecutive cycles (STAGE=0) -> each appears on outputs exactly one cycle later, in order. Toggling in_valid 1,0,1 gives out_valid 1,0,1 delayed by one cycle.
- 16-stage chain: x=0x9B75, y=0, z=34315 (30 deg) -> after 16 cycles x_out ≈ 56756 (0xDDB4) and y_out ≈ 32768 (0x8000), each within ±16 LSB; z_out within ±16 LSB of 0.
